// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field descriptions into 32-bit words, queues
// them in a 2-entry FIFO and writes them to consecutive word addresses of
// the instruction memory under write backpressure.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  im_we,
  input  logic                  im_ready,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic [15:0]           count,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           NOP  = 32'h0000_0013;

  logic [31:0]           enc_word;
  logic                  enc_err;
  logic [31:0]           mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic                  err_q, err_d;
  logic                  push, pop;

  // Pack the offered fields into one RV32I word; flag illegal formats and
  // odd branch/jump offsets (bit 0 simply has no slot in B/J words).
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    unique case (in_fmt)
      3'b000: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'b001: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'b010: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = in_imm[0];
      end
      3'b011: enc_word = {in_imm[31:12], in_rd, in_opcode};
      3'b100: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = in_imm[0];
      end
      3'b101: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Full FIFO blocks input even if the head drains this cycle (no bypass).
  assign in_ready = (occ_q != 2'd2) && !restart;
  assign im_we    = (occ_q != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = im_we && im_ready;

  // Next-state for pointers, occupancy, write address, count and err;
  // restart overrides every other update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (restart) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
      addr_d   = BASE;
      count_d  = 16'd0;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        err_d    = err_q | enc_err;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        addr_d   = addr_q + ADDR_WIDTH'(4);
        count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      end
      if (push && !pop)      occ_d = occ_q + 2'd1;
      else if (pop && !push) occ_d = occ_q - 2'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      addr_q   <= BASE;
      count_q  <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; cleared by reset so im_wdata reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= 32'd0;
      mem_q[1] <= 32'd0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign im_addr  = addr_q;
  assign im_wdata = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected word/address
// pairs on accept, a monitor pops and compares on every memory write.
// A second instance with ADDR_WIDTH=4 shares inputs to exercise wrap.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, restart, in_valid, im_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, im_we, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [15:0] count;

  logic        in_ready4, im_we4, err4;
  logic [3:0]  im_addr4;
  logic [31:0] im_wdata4;
  logic [15:0] count4;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  a;
  } exp_t;
  exp_t sb[$];
  logic [7:0] exp_addr;
  int checks = 0, failures = 0, pops = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .err(err));

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .im_we(im_we4), .im_ready(im_ready), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .count(count4), .err(err4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write transfer pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && !restart && im_we && im_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", im_wdata, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        chk("wdata", im_wdata, e.w);
        chk("addr", {24'd0, im_addr}, {24'd0, e.a});
        chk("wdata_aw4", im_wdata4, e.w);
        chk("addr_aw4", {28'd0, im_addr4}, {28'd0, e.a[3:0]});
      end
    end
  end

  // Offer one field set; record the expected word when it is accepted.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp_w);
    int n = 0;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{w: exp_w, a: exp_addr});
        exp_addr += 8'd4;
        break;
      end
      if (++n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || im_we) begin
      @(posedge clk); #1;
      if (++n > 50) begin
        chk("drain_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    sb.delete();
    exp_addr = 8'd0;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; im_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; exp_addr = 8'd0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_im_we", {31'd0, im_we}, 32'd0);
    chk("rst_im_addr", {24'd0, im_addr}, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Five back-to-back inputs with memory always ready.
    im_ready = 1'b1;
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093);
    send(3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h002081B3);
    send(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFE000EE3);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7);
    drain();
    chk("count_after5", {16'd0, count}, 32'd5);
    chk("err_after5", {31'd0, err}, 32'd0);

    // JAL, then JAL with odd offset: same word, err set.
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h010000EF);
    chk("err_jal_even", {31'd0, err}, 32'd0);
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd17, 32'h010000EF);
    chk("err_jal_odd", {31'd0, err}, 32'd1);
    drain();
    do_restart();
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("addr_reload", {24'd0, im_addr}, 32'd0);

    // Illegal format becomes NOP and sets err; restart clears it.
    send(3'b110, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000013);
    chk("err_illegal", {31'd0, err}, 32'd1);
    drain();
    chk("count_illegal", {16'd0, count}, 32'd1);
    do_restart();
    chk("err_cleared2", {31'd0, err}, 32'd0);
    chk("addr_reload2", {24'd0, im_addr}, 32'd0);
    chk("count_cleared", {16'd0, count}, 32'd0);

    // Backpressure: two accepts fill the FIFO, third is stalled even when
    // im_ready rises (no bypass), then everything drains in order.
    im_ready = 1'b0;
    send(3'b000, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100113);
    send(3'b000, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200193);
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    im_ready = 1'b1;
    @(negedge clk);
    chk("full_no_bypass", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    send(3'b000, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300213);
    drain();
    chk("count_bp", {16'd0, count}, 32'd3);
    chk("sb_empty_bp", sb.size(), 32'd0);

    // Restart while full with an input offered.
    do_restart();
    im_ready = 1'b0;
    send(3'b000, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h00400293);
    send(3'b000, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500313);
    in_valid = 1'b1;
    restart  = 1'b1;
    sb.delete();
    exp_addr = 8'd0;
    @(negedge clk);
    chk("restart_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart_im_we", {31'd0, im_we}, 32'd0);
    chk("restart_count", {16'd0, count}, 32'd0);
    chk("restart_addr", {24'd0, im_addr}, 32'd0);
    im_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("restart_still_empty", {31'd0, im_we}, 32'd0);
    chk("total_pops", pops, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory loader: the inverse of the opcode-to-control decode path. It accepts field-level instruction descriptions (format, opcode, registers, funct fields, immediate) over a valid/ready handshake. It packs each one into a 32-bit RV32I word and buffers it in a 2-entry FIFO. It writes the words to consecutive word-aligned instruction-memory addresses under memory backpressure. It is used by the bench and boot path to build programs for the single-cycle core.

## Interface
- ADDR_WIDTH, 8: byte-address width of the instruction memory.
- BASE_ADDR, 0: first write address after reset/restart. Must be a multiple of 4.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous: flush FIFO, reload address, clear err
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 110/111 illegal (same I/S/B/U/J codes as IMMctrl)
- in_opcode  in  7  opcode bits [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7  used by R format only
- in_imm  in  32  byte-offset/value immediate, sign-extended by sender
- im_we  out  1  write request (FIFO non-empty)
- im_ready  in  1  memory accepts write
- im_addr  out  ADDR_WIDTH  byte address of current write
- im_wdata  out  32  encoded word at FIFO head
- count  out  16  words written since reset/restart, saturating at 0xFFFF
- err  out  1  sticky: illegal format or misaligned B/J immediate seen

## Operation
- Word packing. Fields not in a format are ignored.
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Illegal fmt: the word is replaced by NOP 0x00000013 and err is set.
- B/J with imm[0]=1: imm[0] is dropped, the word is encoded normally, and err is set.
- Input accept: in_valid && in_ready. The packed word is pushed into the FIFO.
- FIFO: 2 entries, in order.
  - in_ready = (occupancy < 2) && !restart.
  - No same-cycle bypass when full: in_ready stays low even if im_ready is high.
- Output transfer: im_we && im_ready.
  - Pops the head.
  - im_addr advances by 4, wrapping modulo 2^ADDR_WIDTH.
  - count increments.
- Simultaneous accept and transfer: occupancy is unchanged and ordering is preserved.
- restart, a single-cycle pulse, takes priority over everything:
  - FIFO emptied; a same-cycle accept is dropped (in_ready is low); a same-cycle transfer is not counted.
  - im_addr reloads to BASE_ADDR.
  - count and err clear.
- im_wdata and im_addr stay stable while im_we && !im_ready.

## Timing
- Reset values (asynchronous, all outputs): in_ready 1, im_we 0, im_addr BASE_ADDR, im_wdata 0, count 0, err 0.
- Latency: a word accepted at edge N shows im_we=1 with that word from just after edge N, so it can transfer at edge N+1.
- Throughput: 1 word/cycle when im_ready is held high.
- Backpressure: with im_ready low, the 3rd consecutive input sees in_ready=0 after 2 accepts.
- err updates at the accepting edge and is visible the next cycle.
- Reset mid-operation: all state returns to reset values immediately, and in-flight words are lost.

## Test plan
- Reset, then im_ready=1 and five back-to-back inputs:
  - addi x1,x0,5 (I) -> 0x00500093 at 0x00.
  - add x3,x1,x2 (R) -> 0x002081B3 at 0x04.
  - sw x2,8(x1) (S) -> 0x0020A423 at 0x08.
  - beq x0,x0,-4 (B) -> 0xFE000EE3 at 0x0C.
  - lui x5,0x12345000 (U) -> 0x123452B7 at 0x10.
  - Final state: count=5, err=0.
- jal x1,16 (J) -> 0x010000EF. Then jal with imm=17 -> 0x010000EF again, err=1.
- in_fmt=110 -> im_wdata 0x00000013 and err=1. A subsequent restart clears err and returns im_addr to BASE_ADDR.
- im_ready=0 with 3 inputs offered:
  - 2 accepted, in_ready=0 on the 3rd.
  - When im_ready rises, words drain in order at consecutive addresses.
  - No word is lost or duplicated.
- ADDR_WIDTH=4, 5 writes from 0: addresses 0, 4, 8, 0xC, then wrap to 0.
- restart asserted with FIFO full and in_valid=1: the next cycle shows im_we=0, count=0, im_addr=BASE_ADDR, and the offered input is not accepted.
